// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch-stage types, condition codes and PC constants
//
// Purpose: definitions shared by the PC sequencer and the later pipelined fetch.
//   state_t        : sequencer FSM states (IDLE, INC, TGT)
//   CC_*           : WISC branch condition-code encodings
//   PC_RESET       : architectural PC after reset
//   PC_STEP        : sequential fetch increment (one 16-bit instruction word)
//   sext_offset()  : turns a 9-bit word offset into a 16-bit byte offset
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INC  = 2'd1,
    TGT  = 2'd2
  } state_t;

  localparam logic [2:0] CC_NE     = 3'd0;  // Z=0
  localparam logic [2:0] CC_EQ     = 3'd1;  // Z=1
  localparam logic [2:0] CC_GT     = 3'd2;  // Z=0 and N=0
  localparam logic [2:0] CC_LT     = 3'd3;  // N=1
  localparam logic [2:0] CC_GE     = 3'd4;  // Z=1 or (Z=0 and N=0)
  localparam logic [2:0] CC_LE     = 3'd5;  // N=1 or Z=1
  localparam logic [2:0] CC_OVF    = 3'd6;  // V=1
  localparam logic [2:0] CC_UNCOND = 3'd7;  // always

  localparam logic [15:0] PC_RESET = 16'h0000;
  localparam logic [15:0] PC_STEP  = 16'h0002;

  // Offset is in instruction words; the PC is a byte address, hence the
  // extra zero LSB after sign extension.
  function automatic logic [15:0] sext_offset(input logic [8:0] off);
    return {{6{off[8]}}, off, 1'b0};
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - request/status bundle between fetch control and the PC sequencer
//
// Purpose: groups the next-PC request and its status outputs.
//   start   : request a next-PC computation (taken only while ready=1)
//   branch  : instruction is a branch
//   C       : 3-bit condition code
//   I       : 9-bit signed offset in instruction words
//   F       : flags {Z,V,N}
//   halt    : instruction is HLT
//   pc      : architectural PC
//   ready   : sequencer idle
//   done    : one-cycle pulse, pc holds the committed value
//   halted  : sticky halt status
// Modports: master drives the request, slave is the sequencer.
interface pc_sequencer_if;

  logic        start;
  logic        branch;
  logic [2:0]  C;
  logic [8:0]  I;
  logic [2:0]  F;
  logic        halt;
  logic [15:0] pc;
  logic        ready;
  logic        done;
  logic        halted;

  modport master (
    output start, branch, C, I, F, halt,
    input  pc, ready, done, halted
  );

  modport slave (
    input  start, branch, C, I, F, halt,
    output pc, ready, done, halted
  );

endinterface

// File: rtl/branch_cond_eval.sv
// rtl/branch_cond_eval.sv - WISC branch condition evaluation against the flag register
//
// Purpose: combinational decode of a condition code against the flags.
//   i_c     : condition code (CC_* from fetch_pkg)
//   i_f     : flags {Z,V,N}
//   o_taken : condition holds (caller still qualifies with "is a branch")
module branch_cond_eval
  import fetch_pkg::*;
(
  input  logic [2:0] i_c,
  input  logic [2:0] i_f,
  output logic       o_taken
);

  logic w_z;
  logic w_v;
  logic w_n;

  assign {w_z, w_v, w_n} = i_f;

  always_comb begin
    o_taken = 1'b0;
    case (i_c)
      CC_NE:     o_taken = !w_z;
      CC_EQ:     o_taken = w_z;
      CC_GT:     o_taken = !w_z && !w_n;
      CC_LT:     o_taken = w_n;
      CC_GE:     o_taken = w_z || (!w_z && !w_n);
      CC_LE:     o_taken = w_n || w_z;
      CC_OVF:    o_taken = w_v;
      CC_UNCOND: o_taken = 1'b1;
      default:   o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/rca16.sv
// rtl/rca16.sv - 16-bit ripple-carry adder, carry-out discarded
//
// Purpose: plain ripple-carry adder; PC arithmetic is modulo 2^16 so no
// carry-out is produced.
//   i_x, i_y : 16-bit operands
//   i_cin    : carry into bit 0
//   o_sum    : 16-bit sum
module rca16 (
  input  logic [15:0] i_x,
  input  logic [15:0] i_y,
  input  logic        i_cin,
  output logic [15:0] o_sum
);

  logic w_carry;

  always_comb begin
    w_carry = i_cin;
    o_sum   = '0;
    for (int k = 0; k < 16; k++) begin
      o_sum[k] = i_x[k] ^ i_y[k] ^ w_carry;
      w_carry  = (i_x[k] & i_y[k]) | (i_x[k] & w_carry) | (i_y[k] & w_carry);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - multi-cycle next-PC controller sharing one adder for PC+2 and branch target
//
// Purpose: holds the architectural PC and commits one new PC per request.
// A single ripple-carry adder first computes PC+2 (INC) and, for taken
// branches, then (PC+2)+offset (TGT).
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : pc_sequencer_if.slave (start/branch/C/I/F/halt in, pc/ready/done/halted out)
module pc_sequencer
  import fetch_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  pc_sequencer_if.slave        bus
);

  state_t      r_state;
  state_t      w_next_state;

  logic [15:0] r_pc;
  logic [15:0] r_pc_plus2;
  logic        r_done;
  logic        r_halted;

  // Request fields captured at acceptance; the bus may change afterwards.
  logic        r_branch;
  logic [2:0]  r_c;
  logic [8:0]  r_i;
  logic [2:0]  r_f;

  logic        w_accept;
  logic        w_halt_accept;
  logic        w_commit;
  logic        w_cond;
  logic        w_taken;
  logic [15:0] w_add_x;
  logic [15:0] w_add_y;
  logic [15:0] w_sum;

  branch_cond_eval u_cond (
    .i_c     (r_c),
    .i_f     (r_f),
    .o_taken (w_cond)
  );

  assign w_taken = r_branch && w_cond;

  rca16 u_adder (
    .i_x   (w_add_x),
    .i_y   (w_add_y),
    .i_cin (1'b0),
    .o_sum (w_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state plus adder operand selection. Outside TGT the adder is
  // parked on pc+2 so INC needs no special operand path.
  always_comb begin
    w_next_state  = r_state;
    w_add_x       = r_pc;
    w_add_y       = PC_STEP;
    w_accept      = 1'b0;
    w_halt_accept = 1'b0;
    w_commit      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start && !r_halted) begin
          if (bus.halt) begin
            w_halt_accept = 1'b1;
          end else begin
            w_accept     = 1'b1;
            w_next_state = INC;
          end
        end
      end
      INC: begin
        if (w_taken) begin
          w_next_state = TGT;
        end else begin
          w_commit     = 1'b1;
          w_next_state = IDLE;
        end
      end
      TGT: begin
        w_add_x      = r_pc_plus2;
        w_add_y      = sext_offset(r_i);
        w_commit     = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= PC_RESET;
      r_pc_plus2 <= PC_RESET;
      r_done     <= 1'b0;
      r_halted   <= 1'b0;
      r_branch   <= 1'b0;
      r_c        <= 3'd0;
      r_i        <= 9'd0;
      r_f        <= 3'd0;
    end else begin
      // A halting request finishes immediately: no PC change, just the pulse.
      r_done <= w_commit || w_halt_accept;
      if (w_halt_accept) begin
        r_halted <= 1'b1;
      end
      if (w_accept) begin
        r_branch <= bus.branch;
        r_c      <= bus.C;
        r_i      <= bus.I;
        r_f      <= bus.F;
      end
      if (r_state == INC) begin
        r_pc_plus2 <= w_sum;
      end
      if (w_commit) begin
        r_pc <= w_sum;
      end
    end
  end

  assign bus.pc     = r_pc;
  assign bus.ready  = (r_state == IDLE);
  assign bus.done   = r_done;
  assign bus.halted = r_halted;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer against a transaction-level model
module tb_pc_sequencer;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (got running, expected finished)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A request is a transaction: its result PC is computed once at acceptance
  // with plain arithmetic and appears after a fixed latency.
  function automatic logic cond_ok(input logic [2:0] c, input logic [2:0] f);
    logic z, v, n;
    z = f[2]; v = f[1]; n = f[0];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!z && !n);
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  logic [15:0] m_pc;
  logic [15:0] m_tgt;
  logic        m_halted;
  logic        m_done;
  int          m_wait;     // edges still to go before the pending result lands
  logic        m_valid = 1'b0;

  always @(posedge clk) begin
    logic [15:0] np, nt;
    logic        nh, nd;
    int          nw;
    np = m_pc; nt = m_tgt; nh = m_halted; nd = 1'b0; nw = m_wait;
    if (rst) begin
      np = 16'h0000; nh = 1'b0; nw = 0;
    end else if (nw != 0) begin
      nw = nw - 1;
      if (nw == 0) begin
        np = nt;
        nd = 1'b1;
      end
    end else if (bus.start && !nh) begin
      if (bus.halt) begin
        nh = 1'b1;
        nd = 1'b1;
      end else if (bus.branch && cond_ok(bus.C, bus.F)) begin
        nt = 16'(int'(m_pc) + 2 + 2 * int'($signed(bus.I)));
        nw = 2;
      end else begin
        nt = 16'(int'(m_pc) + 2);
        nw = 1;
      end
    end
    m_pc     <= np;
    m_tgt    <= nt;
    m_halted <= nh;
    m_done   <= nd;
    m_wait   <= nw;
    m_valid  <= 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("cyc_pc",     bus.pc,              m_pc);
      chk("cyc_ready",  16'(bus.ready),      16'(m_wait == 0));
      chk("cyc_done",   16'(bus.done),       16'(m_done));
      chk("cyc_halted", 16'(bus.halted),     16'(m_halted));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic go_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Presents one request for a single edge, then scrambles the request fields.
  task automatic issue(input logic br, input logic [2:0] c, input logic [8:0] i,
                       input logic [2:0] f, input logic h);
    bus.start = 1'b1; bus.branch = br; bus.C = c; bus.I = i; bus.F = f; bus.halt = h;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.branch = 1'($urandom);
    bus.C      = 3'($urandom);
    bus.I      = 9'($urandom);
    bus.F      = 3'($urandom);
    bus.halt   = 1'($urandom);
  endtask

  task automatic wait_done(input string nm, input int exp_lat);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_done"}, 16'(bus.done), 16'd1);
    chk({nm, "_lat"},  16'(n),        16'(exp_lat));
  endtask

  // From reset, one unconditional taken branch lands pc at 2 + 2*off.
  task automatic set_pc(input logic [8:0] off);
    go_reset();
    issue(1'b1, 3'd7, off, 3'd0, 1'b0);
    wait_done("setpc", 2);
  endtask

  logic [15:0] seq_q[$];

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.branch = 1'b0; bus.C = 3'd0; bus.I = 9'd0;
    bus.F = 3'd0; bus.halt = 1'b0;
    go_reset();

    chk("rst_pc",     bus.pc,              16'h0000);
    chk("rst_ready",  16'(bus.ready),      16'd1);
    chk("rst_done",   16'(bus.done),       16'd0);
    chk("rst_halted", 16'(bus.halted),     16'd0);

    // sequential step from 0
    issue(1'b0, 3'd0, 9'd0, 3'd0, 1'b0);
    wait_done("seq0", 1);
    chk("seq0_pc",    bus.pc,         16'h0002);
    chk("seq0_ready", 16'(bus.ready), 16'd1);
    @(negedge clk);
    chk("seq0_once",  16'(bus.done),  16'd0);

    // unconditional backward one word from 0x10
    set_pc(9'd7);
    chk("pc10", bus.pc, 16'h0010);
    issue(1'b1, 3'd7, 9'h1FF, 3'd0, 1'b0);
    wait_done("uncond", 2);
    chk("uncond_pc", bus.pc, 16'h0010);

    // EQ with Z=0 -> not taken
    issue(1'b1, 3'd1, 9'h004, 3'b000, 1'b0);
    wait_done("eq_nt", 1);
    chk("eq_nt_pc", bus.pc, 16'h0012);

    // EQ with Z=1 -> taken
    set_pc(9'd7);
    issue(1'b1, 3'd1, 9'h004, 3'b100, 1'b0);
    wait_done("eq_t", 2);
    chk("eq_t_pc", bus.pc, 16'h001A);

    // wrap on sequential step
    set_pc(9'h1FE);
    chk("pcfffe", bus.pc, 16'hFFFE);
    issue(1'b0, 3'd7, 9'h0FF, 3'd0, 1'b0);
    wait_done("wrap", 1);
    chk("wrap_pc", bus.pc, 16'h0000);

    // wrap through the target computation
    set_pc(9'h1F7);
    chk("pcfff0", bus.pc, 16'hFFF0);
    issue(1'b1, 3'd7, 9'h0FF, 3'd0, 1'b0);
    wait_done("wrapt", 2);
    chk("wrapt_pc", bus.pc, 16'h01F0);

    // halt, then ignored requests
    set_pc(9'h01F);
    chk("pc40", bus.pc, 16'h0040);
    issue(1'b0, 3'd0, 9'd0, 3'd0, 1'b1);
    wait_done("halt", 0);
    chk("halt_flag", 16'(bus.halted), 16'd1);
    chk("halt_pc",   bus.pc,          16'h0040);
    issue(1'b1, 3'd7, 9'h010, 3'd0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk("ign_done",  16'(bus.done),  16'd0);
      chk("ign_ready", 16'(bus.ready), 16'd1);
      @(negedge clk);
    end
    chk("ign_pc", bus.pc, 16'h0040);

    // reset while computing the target
    set_pc(9'd7);
    issue(1'b1, 3'd7, 9'h005, 3'd0, 1'b0);
    @(negedge clk);
    chk("tgt_busy", 16'(bus.ready), 16'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_pc",     bus.pc,          16'h0000);
    chk("abort_done",   16'(bus.done),   16'd0);
    chk("abort_ready",  16'(bus.ready),  16'd1);
    chk("abort_halted", 16'(bus.halted), 16'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_nodone", 16'(bus.done), 16'd0);
    end

    // back-to-back sequential requests
    go_reset();
    bus.start = 1'b1; bus.branch = 1'b0; bus.halt = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seq_q.push_back(bus.pc);
    end
    bus.start = 1'b0;
    chk("b2b_count", 16'(seq_q.size()), 16'd3);
    for (int k = 0; k < 3; k++) begin
      if (k < seq_q.size()) chk("b2b_pc", seq_q[k], 16'(2 * (k + 1)));
    end

    // randomized traffic, checked every cycle against the model
    for (int k = 0; k < 1500; k++) begin
      rst        = ($urandom_range(0, 149) == 0);
      bus.start  = ($urandom_range(0, 9) < 7);
      bus.branch = 1'($urandom);
      bus.C      = 3'($urandom);
      bus.I      = 9'($urandom);
      bus.F      = 3'($urandom);
      bus.halt   = ($urandom_range(0, 59) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    bus.start = 1'b0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
